// File: rtl/lap_display_ctrl.sv
// rtl/lap_display_ctrl.sv - lap capture, hold and recall between stopwatch time and 7-segment display
// Optional LAP_DELTA_EN: store splits (TIME minus previous capture) instead of absolute time.
module lap_display_ctrl #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 200000000
) (
    input  logic        CLK,
    input  logic        XRST,
    input  logic        XLAP,
    input  logic        XRECALL,
    input  logic        CLEAR,
    input  logic        TIMER_RUN,
    input  logic [15:0] TIME,
    output logic [15:0] DISP_DATA,
    output logic [4:0]  LAP_CNT,
    output logic [3:0]  IDX,
    output logic        RECALL_MODE,
    output logic        FULL
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

    typedef enum logic [1:0] {LIVE, HOLD, RECALL} state_t;

    state_t        state;
    logic          lap_hist;
    logic          recall_hist;
    logic [HW-1:0] hold_ctr;
    logic [15:0]   hold_val;
    logic [15:0]   lap_buf [DEPTH];

    logic          lap_press;
    logic          recall_press;
    logic          do_recall_enter;
    logic          do_capture;
    logic [3:0]    next_idx;
    logic [15:0]   capture_val;

    assign lap_press    = lap_hist & ~XLAP;
    assign recall_press = recall_hist & ~XRECALL;

    // A recall press outranks a lap press in the same cycle even when it is ignored.
    assign do_recall_enter = (state != RECALL) && recall_press && (LAP_CNT != 5'd0);
    assign do_capture      = !CLEAR && (state != RECALL) && lap_press && !recall_press && TIMER_RUN;

    assign next_idx    = ({1'b0, IDX} == LAP_CNT - 5'd1) ? 4'd0 : IDX + 4'd1;
    assign FULL        = (LAP_CNT == DEPTH_CNT);
    assign RECALL_MODE = (state == RECALL);

`ifdef LAP_DELTA_EN
    logic [15:0] prev_cap;

    function automatic logic [15:0] bcd_sub(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        borrow;
        logic [4:0]  d;
        borrow = 1'b0;
        r      = '0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, borrow};
            if (d[4]) begin
                d      = d + 5'd10;
                borrow = 1'b1;
            end else begin
                borrow = 1'b0;
            end
            r[4*i +: 4] = d[3:0];
        end
        return r;
    endfunction

    assign capture_val = bcd_sub(TIME, prev_cap);

    always_ff @(posedge CLK or posedge XRST) begin
        if (XRST) begin
            prev_cap <= '0;
        end else if (CLEAR) begin
            prev_cap <= '0;
        end else if (do_capture) begin
            prev_cap <= TIME;
        end
    end
`else
    assign capture_val = TIME;
`endif

    always_ff @(posedge CLK or posedge XRST) begin
        if (XRST) begin
            state       <= LIVE;
            lap_hist    <= 1'b1;
            recall_hist <= 1'b1;
            hold_ctr    <= '0;
            hold_val    <= '0;
            DISP_DATA   <= '0;
            LAP_CNT     <= '0;
            IDX         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                lap_buf[i] <= '0;
            end
        end else begin
            lap_hist    <= XLAP;
            recall_hist <= XRECALL;
            if (CLEAR) begin
                LAP_CNT   <= '0;
                IDX       <= '0;
                state     <= LIVE;
                hold_ctr  <= '0;
                DISP_DATA <= TIME;
            end else begin
                case (state)
                    RECALL: begin
                        if (recall_press) begin
                            state     <= LIVE;
                            IDX       <= '0;
                            DISP_DATA <= TIME;
                        end else if (lap_press) begin
                            IDX       <= next_idx;
                            DISP_DATA <= lap_buf[next_idx[AW-1:0]];
                        end
                    end
                    default: begin
                        if (do_recall_enter) begin
                            state     <= RECALL;
                            IDX       <= '0;
                            hold_ctr  <= '0;
                            DISP_DATA <= lap_buf[0];
                        end else if (do_capture) begin
                            if (!FULL) begin
                                lap_buf[LAP_CNT[AW-1:0]] <= capture_val;
                                LAP_CNT                  <= LAP_CNT + 5'd1;
                            end
                            hold_val  <= capture_val;
                            hold_ctr  <= '0;
                            state     <= HOLD;
                            DISP_DATA <= capture_val;
                        end else if (state == HOLD) begin
                            if (hold_ctr == HOLD_LAST) begin
                                state     <= LIVE;
                                hold_ctr  <= '0;
                                DISP_DATA <= TIME;
                            end else begin
                                hold_ctr  <= hold_ctr + 1'b1;
                                DISP_DATA <= hold_val;
                            end
                        end else begin
                            DISP_DATA <= TIME;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lap_display_ctrl.sv
// tb/tb_lap_display_ctrl.sv - scoreboard bench for lap_display_ctrl against a behavioural lap model
module tb_lap_display_ctrl;

    localparam int DEPTH = 8;
    localparam int HOLD  = 10;

    logic        CLK = 1'b0;
    logic        XRST;
    logic        XLAP;
    logic        XRECALL;
    logic        CLEAR;
    logic        TIMER_RUN;
    logic [15:0] TIME;
    logic [15:0] DISP_DATA;
    logic [4:0]  LAP_CNT;
    logic [3:0]  IDX;
    logic        RECALL_MODE;
    logic        FULL;

    lap_display_ctrl #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .CLK(CLK), .XRST(XRST), .XLAP(XLAP), .XRECALL(XRECALL), .CLEAR(CLEAR),
        .TIMER_RUN(TIMER_RUN), .TIME(TIME), .DISP_DATA(DISP_DATA), .LAP_CNT(LAP_CNT),
        .IDX(IDX), .RECALL_MODE(RECALL_MODE), .FULL(FULL)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] disp;
        logic [4:0]  cnt;
        logic [3:0]  idx;
        logic        rm;
        logic        full;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode is "live", "hold" or "recall"; hold_left counts display cycles still owed.
    string       m_mode;
    int          m_cnt, m_idx, m_hold_left, m_prev_cap;
    logic [15:0] m_hold, m_disp;
    logic [15:0] m_buf [DEPTH];
    bit          m_lap_lvl, m_rec_lvl;

    function automatic int bcd2int(input logic [15:0] b);
        return 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] lap_value(input logic [15:0] t);
`ifdef LAP_DELTA_EN
        return int2bcd((bcd2int(t) - m_prev_cap + 10000) % 10000);
`else
        return t;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = "live";
        m_cnt = 0; m_idx = 0; m_hold_left = 0; m_prev_cap = 0;
        m_hold = '0; m_disp = '0;
        m_lap_lvl = 1'b1; m_rec_lvl = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_buf[i] = '0;
    endtask

    task automatic push_expect();
        exp_t e;
        e.disp = m_disp;
        e.cnt  = 5'(m_cnt);
        e.idx  = 4'(m_idx);
        e.rm   = (m_mode == "recall");
        e.full = (m_cnt == DEPTH);
        sb.push_back(e);
    endtask

    task automatic model_step();
        bit lp, rp;
        logic [15:0] v;
        lp = m_lap_lvl && !XLAP;
        rp = m_rec_lvl && !XRECALL;
        m_lap_lvl = XLAP;
        m_rec_lvl = XRECALL;
        if (CLEAR) begin
            m_cnt = 0; m_idx = 0; m_mode = "live"; m_hold_left = 0; m_prev_cap = 0;
            m_disp = TIME;
        end else if (m_mode == "recall") begin
            if (rp) begin
                m_mode = "live"; m_idx = 0; m_disp = TIME;
            end else if (lp) begin
                m_idx = (m_idx + 1) % m_cnt;
                m_disp = m_buf[m_idx];
            end
        end else if (rp && m_cnt > 0) begin
            m_mode = "recall"; m_idx = 0; m_disp = m_buf[0];
        end else if (!rp && lp && TIMER_RUN) begin
            v = lap_value(TIME);
            m_prev_cap = bcd2int(TIME);
            if (m_cnt < DEPTH) begin
                m_buf[m_cnt] = v;
                m_cnt++;
            end
            m_hold = v; m_hold_left = HOLD; m_mode = "hold"; m_disp = v;
        end else if (m_mode == "hold") begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                m_mode = "live"; m_disp = TIME;
            end else begin
                m_disp = m_hold;
            end
        end else begin
            m_disp = TIME;
        end
        push_expect();
    endtask

    task automatic tick();
        XRST = 1'b0;
        model_step();
        @(negedge CLK);
    endtask

    task automatic press_lap();
        XLAP = 1'b0; tick();
        XLAP = 1'b1; tick();
    endtask

    task automatic press_rec();
        XRECALL = 1'b0; tick();
        XRECALL = 1'b1; tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check_zero(input string name);
        chk({name, "_disp"}, 32'(DISP_DATA), 32'h0);
        chk({name, "_cnt"}, 32'(LAP_CNT), 32'h0);
        chk({name, "_idx"}, 32'(IDX), 32'h0);
        chk({name, "_recall"}, 32'(RECALL_MODE), 32'h0);
        chk({name, "_full"}, 32'(FULL), 32'h0);
    endtask

    // Reset dropped between edges must clear outputs without waiting for a clock.
    task automatic reset_mid();
        exp_t z;
        XRST = 1'b1;
        #1;
        check_zero("async_rst");
        model_reset();
        z = '0;
        sb.push_back(z);
        @(negedge CLK);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("disp", 32'(DISP_DATA), 32'(e.disp));
                chk("lap_cnt", 32'(LAP_CNT), 32'(e.cnt));
                chk("idx", 32'(IDX), 32'(e.idx));
                chk("recall_mode", 32'(RECALL_MODE), 32'(e.rm));
                chk("full", 32'(FULL), 32'(e.full));
            end
        end
    end

    initial begin : driver
        XRST = 1'b1; XLAP = 1'b1; XRECALL = 1'b1; CLEAR = 1'b0; TIMER_RUN = 1'b0; TIME = '0;
        model_reset();
        repeat (3) @(negedge CLK);
        check_zero("reset");

        TIMER_RUN = 1'b1;
        TIME = 16'h0123;
        press_lap();
        for (int i = 0; i < 12; i++) begin
            TIME = int2bcd(200 + i);
            tick();
        end

        CLEAR = 1'b1; tick(); CLEAR = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            TIME = int2bcd(i);
            press_lap();
        end
        idle(12);
        press_rec();
        repeat (9) press_lap();
        press_rec();

        CLEAR = 1'b1; tick(); CLEAR = 1'b0;
        press_rec();
        TIMER_RUN = 1'b0; press_lap(); TIMER_RUN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            TIME = int2bcd($urandom_range(0, 9999));
            press_lap();
        end
        idle(12);
        XLAP = 1'b0; XRECALL = 1'b0; tick();
        XLAP = 1'b1; XRECALL = 1'b1; tick();
        press_lap();
        XLAP = 1'b0; CLEAR = 1'b1; tick();
        XLAP = 1'b1; CLEAR = 1'b0; tick();

        TIME = 16'h0456;
        press_lap();
        idle(3);
        reset_mid();
        idle(2);

        TIMER_RUN = 1'b1;
        TIME = 16'h0150; press_lap(); idle(3);
        TIME = 16'h0325; press_lap(); idle(2);
        press_rec(); press_lap(); press_lap(); press_rec();

        TIME = 16'h0777;
        XLAP = 1'b0;
        repeat (100) tick();
        XLAP = 1'b1;
        idle(12);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) XLAP = ~XLAP;
            if ($urandom_range(0, 9) == 0) XRECALL = ~XRECALL;
            CLEAR = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) TIMER_RUN = ~TIMER_RUN;
            if ($urandom_range(0, 2) == 0) TIME = int2bcd($urandom_range(0, 9999));
            tick();
        end
        XLAP = 1'b1; XRECALL = 1'b1; CLEAR = 1'b0;
        idle(2);

        repeat (3) @(posedge CLK);
        #2;
        chk("scoreboard_drain", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
